// File: rtl/redirect_gen.sv
// Redirect generator: picks the oldest mispredicting write-back (or a
// commit-side flush), holds it as a redirect for the front end, and keeps
// a squash window open until the squashing instruction commits.

package types;
   typedef struct packed {
      logic [15:0] opid;
      logic        misp;
      logic        flush;
      logic        retry;
      logic [3:0]  brid;
      logic [4:0]  ldid;
      logic [4:0]  stid;
      logic [2:0]  delta;
      logic [1:0]  bank;
      logic [1:0]  pat;
      logic [1:0]  patb;
      logic [15:0] gh;
      logic [7:0]  ghi;
      logic [7:0]  ght;
      logic [63:0] pc;
      logic [63:0] npc;
      logic        branch;
      logic        jal;
      logic        jalr;
   } exe_bundle_t;

   typedef struct packed {
      logic [15:0] opid;
      logic [15:0] topid;
      logic [3:0]  brid;
      logic [4:0]  ldid;
      logic [4:0]  stid;
      logic [2:0]  delta;
      logic [1:0]  bank;
      logic [1:0]  pat;
      logic [1:0]  patb;
      logic [15:0] gh;
      logic [7:0]  ghi;
      logic [7:0]  ght;
      logic [63:0] pc;
      logic [63:0] npc;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        rollback;
   } red_bundle_t;
endpackage

// Per-port qualification: is this write-back a usable misprediction, and
// how old is it relative to the ROB head.
module redirect_lane #(
   parameter int OPW = 15
) (
   input  logic           valid,
   input  logic           misp,
   input  logic [OPW:0]   opid,
   input  logic [OPW-1:0] head,
   input  logic [OPW-1:0] sq,
   input  logic           busy,
   output logic           cand,
   output logic [OPW-1:0] age
);
   logic [OPW-1:0] sq_age;

   // Modular ages only; a raw compare of opids would break at the wrap.
   always_comb begin
      age    = opid[OPW-1:0] - head;
      sq_age = sq - head;
      cand   = valid && opid[OPW] && misp && (!busy || (age < sq_age));
   end
endmodule

module redirect_gen #(
   parameter int EXE_NUM = 2,
   parameter int OPW     = 15
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [EXE_NUM-1:0]                exe_valid,
   input  types::exe_bundle_t [EXE_NUM-1:0]  exe,
   input  logic [15:0]                       head_opid,
   input  logic                              com_valid,
   input  logic [15:0]                       com_opid,
   input  logic                              flush_valid,
   input  logic [63:0]                       flush_pc,
   input  logic [15:0]                       flush_opid,
   output logic                              red_valid,
   input  logic                              red_ready,
   output types::red_bundle_t                red,
   output logic                              busy
);
   typedef enum logic [1:0] {IDLE, PEND, WAIT} state_t;

   state_t                          state, state_nx;
   logic [15:0]                     sq_opid;
   logic [EXE_NUM-1:0]              cand;
   logic [EXE_NUM-1:0][OPW-1:0]     age;
   logic                            sel_found;
   logic [OPW-1:0]                  sel_age;
   types::exe_bundle_t              sel_exe;
   types::red_bundle_t              new_red;
   logic [15:0]                     new_sq;
   logic                            hit;
   logic                            load;
   logic [EXE_NUM-1:0]              unused_fr;
   logic                            unused_hd;

   assign busy      = (state != IDLE);
   assign red_valid = (state == PEND);
   assign unused_hd = head_opid[15];

   for (genvar i = 0; i < EXE_NUM; i++) begin : g_lane
      redirect_lane #(.OPW(OPW)) u_lane (
         .valid (exe_valid[i]),
         .misp  (exe[i].misp),
         .opid  (exe[i].opid[OPW:0]),
         .head  (head_opid[OPW-1:0]),
         .sq    (sq_opid[OPW-1:0]),
         .busy  (busy),
         .cand  (cand[i]),
         .age   (age[i])
      );
      // Exceptions and retries arrive via the commit-side flush instead.
      assign unused_fr[i] = exe[i].flush ^ exe[i].retry;
   end

   // Oldest candidate wins; strict '<' keeps the lower port on a tie.
   always_comb begin
      sel_found = 1'b0;
      sel_age   = '0;
      sel_exe   = '0;
      for (int i = 0; i < EXE_NUM; i++) begin
         if (cand[i] && (!sel_found || (age[i] < sel_age))) begin
            sel_found = 1'b1;
            sel_age   = age[i];
            sel_exe   = exe[i];
         end
      end
   end

   // Build the next payload; a flush beats any misprediction regardless of age.
   always_comb begin
      new_red = '0;
      if (flush_valid) begin
         new_red.opid     = flush_opid;
         new_red.topid    = flush_opid;
         new_red.npc      = flush_pc;
         new_red.rollback = 1'b0;
         new_sq           = flush_opid;
      end else begin
         new_red.opid     = sel_exe.opid;
         new_red.topid    = sel_exe.opid;
         new_red.brid     = sel_exe.brid;
         new_red.ldid     = sel_exe.ldid;
         new_red.stid     = sel_exe.stid;
         new_red.delta    = sel_exe.delta;
         new_red.bank     = sel_exe.bank;
         new_red.pat      = sel_exe.pat;
         new_red.patb     = sel_exe.patb;
         new_red.gh       = sel_exe.gh;
         new_red.ghi      = sel_exe.ghi;
         new_red.ght      = sel_exe.ght;
         new_red.pc       = sel_exe.pc;
         new_red.npc      = sel_exe.npc;
         new_red.branch   = sel_exe.branch;
         new_red.jal      = sel_exe.jal;
         new_red.jalr     = sel_exe.jalr;
         new_red.rollback = 1'b1;
         new_sq           = sel_exe.opid;
      end
   end

   assign hit = flush_valid || sel_found;

   // Next state: any qualifying hit reloads and (re)enters PEND, which also
   // overrides a same-cycle acceptance of the old payload.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               load     = 1'b1;
               state_nx = PEND;
            end
         end
         PEND: begin
            if (hit) begin
               load     = 1'b1;
               state_nx = PEND;
            end else if (red_ready) begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (hit) begin
               load     = 1'b1;
               state_nx = PEND;
            end else if (!red.rollback) begin
               // A flush empties the ROB, so no commit will close the window.
               state_nx = IDLE;
            end else if (com_valid && (com_opid == sq_opid)) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Payload and squash opid; only change on a load so red holds steady.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red     <= '0;
         sq_opid <= '0;
      end else if (load) begin
         red     <= new_red;
         sq_opid <= new_sq;
      end
   end
endmodule

// File: tb/tb_redirect_gen.sv
// Bench for redirect_gen: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural model.
module tb_redirect_gen;
   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic [1:0]                  exe_valid;
   types::exe_bundle_t [1:0]    exe;
   logic [15:0]                 head_opid;
   logic                        com_valid;
   logic [15:0]                 com_opid;
   logic                        flush_valid;
   logic [63:0]                 flush_pc;
   logic [15:0]                 flush_opid;
   logic                        red_valid;
   logic                        red_ready;
   types::red_bundle_t          red;
   logic                        busy;

   int n_cmp = 0;
   int n_err = 0;

   // model state: 0 idle, 1 redirect pending, 2 waiting for squash to finish
   int          m_st;
   logic [15:0] m_sq;
   logic [15:0] m_opid;
   logic [63:0] m_npc;
   logic        m_rb;

   redirect_gen dut (
      .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .exe(exe),
      .head_opid(head_opid), .com_valid(com_valid), .com_opid(com_opid),
      .flush_valid(flush_valid), .flush_pc(flush_pc), .flush_opid(flush_opid),
      .red_valid(red_valid), .red_ready(red_ready), .red(red), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [15:0] head;
      logic        v0;
      logic [15:0] op0;
      logic        v1;
      logic [15:0] op1;
      logic        fl;
      logic        exp_rv;
      logic [15:0] exp_op;
      logic [63:0] exp_npc;
      logic        exp_rb;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      exe_valid   = '0;
      exe         = '0;
      com_valid   = 1'b0;
      com_opid    = '0;
      flush_valid = 1'b0;
      flush_pc    = '0;
      flush_opid  = '0;
      red_ready   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [14:0] age(input logic [15:0] x, input logic [15:0] h);
      return x[14:0] - h[14:0];
   endfunction

   // Model one clock edge from the inputs currently driven.
   task automatic model_step();
      logic        found;
      logic [14:0] bage, a, sqa;
      logic [15:0] bop;
      logic [63:0] bnpc;
      found = 1'b0; bage = '0; bop = '0; bnpc = '0;
      sqa = age(m_sq, head_opid);
      for (int i = 0; i < 2; i++) begin
         if (exe_valid[i] && exe[i].opid[15] && exe[i].misp) begin
            a = age(exe[i].opid, head_opid);
            if ((m_st == 0 || a < sqa) && (!found || a < bage)) begin
               found = 1'b1; bage = a; bop = exe[i].opid; bnpc = exe[i].npc;
            end
         end
      end
      if (flush_valid) begin
         m_st = 1; m_sq = flush_opid; m_opid = flush_opid; m_npc = flush_pc; m_rb = 1'b0;
      end else if (found) begin
         m_st = 1; m_sq = bop; m_opid = bop; m_npc = bnpc; m_rb = 1'b1;
      end else if (m_st == 1 && red_ready) begin
         m_st = 2;
      end else if (m_st == 2 && (!m_rb || (com_valid && com_opid == m_sq))) begin
         m_st = 0;
      end
   endtask

   initial begin
      logic [15:0] hd;
      idle_inputs();
      head_opid = 16'h0010;

      // reset state
      #2;
      chk("rst red_valid", {63'd0, red_valid}, 64'd0);
      chk("rst busy", {63'd0, busy}, 64'd0);
      do_reset();
      chk("rst red.opid", {48'd0, red.opid}, 64'd0);
      chk("rst red.npc", red.npc, 64'd0);

      // single-cycle vector table, each from a fresh reset
      vt[0] = '{"basic",    16'h0010, 1, 16'h8015, 0, 16'h0000, 0, 1, 16'h8015, 64'hA000, 1};
      vt[1] = '{"older p1", 16'h0010, 1, 16'h8020, 1, 16'h8018, 0, 1, 16'h8018, 64'hB000, 1};
      vt[2] = '{"tie p0",   16'h0010, 1, 16'h8018, 1, 16'h8018, 0, 1, 16'h8018, 64'hA000, 1};
      vt[3] = '{"wrap",     16'h7FF0, 1, 16'hFFFE, 1, 16'h8003, 0, 1, 16'hFFFE, 64'hA000, 1};
      vt[4] = '{"wrap swp", 16'h7FF0, 1, 16'h8003, 1, 16'hFFFE, 0, 1, 16'hFFFE, 64'hB000, 1};
      vt[5] = '{"flush",    16'h0010, 1, 16'h8011, 0, 16'h0000, 1, 1, 16'h8050, 64'h80000004, 0};
      vt[6] = '{"opid inv", 16'h0010, 1, 16'h0015, 1, 16'h8030, 0, 1, 16'h8030, 64'hB000, 1};
      vt[7] = '{"none",     16'h0010, 0, 16'h8015, 0, 16'h8016, 0, 0, 16'h0000, 64'h0, 0};
      vt[8] = '{"head wrp", 16'hFFF8, 1, 16'h8002, 1, 16'hFFFF, 0, 1, 16'hFFFF, 64'hB000, 1};
      for (int k = 0; k < 9; k++) begin
         do_reset();
         head_opid      = vt[k].head;
         exe_valid      = {vt[k].v1, vt[k].v0};
         exe[0].opid    = vt[k].op0; exe[0].misp = 1'b1; exe[0].npc = 64'hA000;
         exe[1].opid    = vt[k].op1; exe[1].misp = 1'b1; exe[1].npc = 64'hB000;
         flush_valid    = vt[k].fl;
         flush_opid     = 16'h8050;
         flush_pc       = 64'h80000004;
         @(negedge clk);
         idle_inputs();
         chk({vt[k].nm, " red_valid"}, {63'd0, red_valid}, {63'd0, vt[k].exp_rv});
         chk({vt[k].nm, " opid"}, {48'd0, red.opid}, {48'd0, vt[k].exp_op});
         chk({vt[k].nm, " npc"}, red.npc, vt[k].exp_npc);
         chk({vt[k].nm, " rollback"}, {63'd0, red.rollback}, {63'd0, vt[k].exp_rb});
      end

      // payload copy, hold while not ready, accept, commit closes window
      do_reset();
      head_opid = 16'h0010;
      exe_valid = 2'b01;
      exe[0].opid = 16'h8015; exe[0].misp = 1'b1; exe[0].npc = 64'h80001000;
      exe[0].pc = 64'h80000FFC; exe[0].brid = 4'd5; exe[0].jal = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("cp topid", {48'd0, red.topid}, 64'h8015);
      chk("cp pc", red.pc, 64'h80000FFC);
      chk("cp brid", {60'd0, red.brid}, 64'd5);
      chk("cp jal", {63'd0, red.jal}, 64'd1);
      @(negedge clk);
      chk("hold valid", {63'd0, red_valid}, 64'd1);
      chk("hold npc", red.npc, 64'h80001000);
      red_ready = 1'b1;
      @(negedge clk);
      red_ready = 1'b0;
      chk("wait red_valid", {63'd0, red_valid}, 64'd0);
      chk("wait busy", {63'd0, busy}, 64'd1);
      com_valid = 1'b1; com_opid = 16'h8015;
      @(negedge clk);
      idle_inputs();
      chk("commit busy", {63'd0, busy}, 64'd0);

      // replacement by older, ignore younger, replacement beats acceptance
      do_reset();
      exe_valid = 2'b01; exe[0].opid = 16'h8030; exe[0].misp = 1'b1;
      @(negedge clk);
      idle_inputs();
      exe_valid = 2'b10; exe[1].opid = 16'h8025; exe[1].misp = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("repl opid", {48'd0, red.opid}, 64'h8025);
      exe_valid = 2'b01; exe[0].opid = 16'h8040; exe[0].misp = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("younger ign", {48'd0, red.opid}, 64'h8025);
      exe_valid = 2'b01; exe[0].opid = 16'h8022; exe[0].misp = 1'b1; red_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("repl>acc valid", {63'd0, red_valid}, 64'd1);
      chk("repl>acc opid", {48'd0, red.opid}, 64'h8022);
      red_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      exe_valid = 2'b01; exe[0].opid = 16'h8021; exe[0].misp = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("wait->pend", {63'd0, red_valid}, 64'd1);
      chk("wait->pend op", {48'd0, red.opid}, 64'h8021);

      // flush beats misprediction; busy drops within two cycles of acceptance
      do_reset();
      flush_valid = 1'b1; flush_pc = 64'h80000004; flush_opid = 16'h8012;
      exe_valid = 2'b01; exe[0].opid = 16'h8011; exe[0].misp = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("fl npc", red.npc, 64'h80000004);
      chk("fl rollback", {63'd0, red.rollback}, 64'd0);
      red_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk("fl busy", {63'd0, busy}, 64'd0);

      // reset during PEND drops the redirect for good
      do_reset();
      exe_valid = 2'b01; exe[0].opid = 16'h8015; exe[0].misp = 1'b1;
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("mid rst valid", {63'd0, red_valid}, 64'd0);
      chk("mid rst busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post rst valid", {63'd0, red_valid}, 64'd0);
      end

      // randomized run against the model
      do_reset();
      m_st = 0; m_sq = '0; m_opid = '0; m_npc = '0; m_rb = 1'b0;
      hd = {1'b1, 15'($urandom)};
      for (int n = 0; n < 3000; n++) begin
         idle_inputs();
         hd[14:0] = hd[14:0] + 15'($urandom_range(0, 1));
         head_opid = hd;
         for (int i = 0; i < 2; i++) begin
            exe_valid[i]  = ($urandom_range(0, 3) == 0);
            exe[i].opid   = {($urandom_range(0, 7) != 0), hd[14:0] + 15'($urandom_range(0, 40))};
            exe[i].misp   = $urandom_range(0, 1) == 1;
            exe[i].flush  = $urandom_range(0, 1) == 1;
            exe[i].retry  = $urandom_range(0, 1) == 1;
            exe[i].npc    = {$urandom, $urandom};
         end
         flush_valid = ($urandom_range(0, 29) == 0);
         flush_opid  = {1'b1, hd[14:0] + 15'($urandom_range(0, 40))};
         flush_pc    = {$urandom, $urandom};
         red_ready   = $urandom_range(0, 1) == 1;
         com_valid   = ($urandom_range(0, 3) == 0);
         com_opid    = ($urandom_range(0, 1) == 1) ? m_sq : 16'($urandom);
         model_step();
         @(negedge clk);
         chk("rnd red_valid", {63'd0, red_valid}, {63'd0, (m_st == 1)});
         chk("rnd busy", {63'd0, busy}, {63'd0, (m_st != 0)});
         if (m_st != 0) begin
            chk("rnd opid", {48'd0, red.opid}, {48'd0, m_opid});
            chk("rnd npc", red.npc, m_npc);
            chk("rnd rollback", {63'd0, red.rollback}, {63'd0, m_rb});
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/redirect_gen.md
REDIRECT_GEN -- requirements
Module: redirect_gen

Interface
REQ-001 SHALL have parameter EXE_NUM, default 2, giving the number of execution write-back ports.
REQ-002 SHALL have parameter OPW, default 15, giving the operation-ID sequence width (opid[14:0]; opid[15] is the valid bit).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port exe_valid, input, EXE_NUM, per-port result valid.
REQ-006 SHALL have port exe, input, EXE_NUM x types::exe_bundle_t, per-port execution results.
REQ-007 SHALL have port head_opid, input, 16, the ROB head operation ID, used as the age origin.
REQ-008 SHALL have port com_valid, input, 1, one instruction committed this cycle.
REQ-009 SHALL have port com_opid, input, 16, the opid of that committed instruction.
REQ-010 SHALL have port flush_valid, input, 1, a commit-side exception or forced flush.
REQ-011 SHALL have port flush_pc, input, 64, the restart PC for that flush.
REQ-012 SHALL have port flush_opid, input, 16, the opid of the flushing instruction.
REQ-013 SHALL have port red_valid, output, 1, a redirect is pending.
REQ-014 SHALL have port red_ready, input, 1, the front end accepts the redirect.
REQ-015 SHALL have port red, output, types::red_bundle_t, the redirect payload.
REQ-016 SHALL have port busy, output, 1, a squash window is active (WAIT or PEND).

Function
REQ-017 SHALL define age(x) = (x[14:0] - head_opid[14:0]) mod 2^OPW; a smaller age is older.
REQ-018 SHALL treat port i as a candidate iff exe_valid[i], exe[i].opid[15] and exe[i].misp are all 1; exe.flush/retry SHALL be ignored.
REQ-019 SHALL discard a candidate that is not older than the currently pending or squashing opid (sq_opid) while busy.
REQ-020 SHALL select the oldest candidate; on an age tie the lower port index wins.
REQ-021 SHALL register the selected candidate, so red_valid rises in cycle t+1 for a candidate presented in cycle t.
REQ-022 SHALL set the misprediction payload: opid=topid=exe.opid; brid, ldid, stid, delta, bank, pat, patb, gh, ghi, ght, pc, npc, branch, jal, jalr copied; rollback=1.
REQ-023 SHALL set the flush payload: opid=topid=flush_opid, npc=flush_pc, rollback=0, all other fields 0.
REQ-024 SHALL give flush_valid priority over every exe candidate in the same cycle, regardless of age.
REQ-025 SHALL implement states IDLE, PEND and WAIT.
REQ-026 SHALL, in IDLE, go to PEND on a candidate or flush and load sq_opid.
REQ-027 SHALL, in PEND, hold red_valid=1 and move to WAIT on red_valid && red_ready.
REQ-028 SHALL, in PEND, overwrite the payload and sq_opid in place with a strictly older candidate or a flush, and stay in PEND.
REQ-029 SHALL, in PEND, give a same-cycle replacement precedence over acceptance: the old payload counts as accepted only if no replacement occurs that cycle, so the state stays PEND with the new payload.
REQ-030 SHALL, in WAIT, hold red_valid=0 and go to PEND on an older candidate or a flush.
REQ-031 SHALL, in WAIT, go to IDLE when com_valid && com_opid == sq_opid.
REQ-032 SHALL, in WAIT, go to IDLE one cycle after an accepted flush redirect, since the flush empties the ROB.
REQ-033 SHALL keep red stable while red_valid is 1 and red_ready is 0, except for a PEND replacement.
REQ-034 SHALL drive busy=1 in PEND and WAIT.
REQ-035 SHALL wrap opid correctly across 2^OPW using modular age only; no raw magnitude compare is permitted.

Reset
REQ-036 SHALL on rst_n=0 asynchronously enter IDLE and clear red_valid, busy, sq_opid and the red bundle to 0.
REQ-037 SHALL accept no candidate until the first clk edge after rst_n deasserts.
REQ-038 SHALL on reset asserted mid-PEND drop the pending redirect with no red_valid pulse after release.

Verification
REQ-039 SHALL pass this scenario: head=0x0010, port0 misp opid=0x8015 npc=0x80001000 -> next cycle red_valid=1, red.opid=0x8015, red.npc=0x80001000, rollback=1.
REQ-040 SHALL pass this scenario: same cycle port0 opid=0x8020 and port1 opid=0x8018 with head=0x0010 -> red.opid=0x8018; equal ages -> port0 wins.
REQ-041 SHALL pass this scenario: PEND with opid 0x8030 and red_ready=0, then port1 misp 0x8025 -> payload replaced with 0x8025; later misp 0x8040 -> ignored.
REQ-042 SHALL pass this scenario: wrap case head=0x7FF0, candidates 0xFFFE and 0x8003 -> 0xFFFE chosen (age 0x0E < 0x13).
REQ-043 SHALL pass this scenario: flush_valid with flush_pc=0x80000004 and a port0 misp in the same cycle -> red.npc=0x80000004, rollback=0; after acceptance busy falls within 2 cycles.
REQ-044 SHALL pass this scenario: WAIT on sq_opid 0x8015, com_valid with com_opid=0x8015 -> busy=0 next cycle; rst_n pulsed low during PEND -> red_valid=0 immediately and stays 0.
